// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants, state enum and tag type for the MAC sequencer
package mac_pkg;

  localparam int DEPTH   = 10;
  localparam int ADDR_W  = 4;
  localparam int RES_W   = 17;
  localparam int ACC_W   = 21;
  localparam int RD_LAT  = 2;
  localparam int DSP_LAT = 3;
  localparam int LAT     = RD_LAT + DSP_LAT;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/mac_tag_pipe.sv
// rtl/mac_tag_pipe.sv - fixed-depth tag shift register tracking BRAM + DSP latency
module mac_tag_pipe
  import mac_pkg::*;
#(
  parameter int DEPTH_P = LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [DEPTH_P];

  // Shift one tag per cycle; flush empties every stage so no stale result strobes escape
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_P; i++) stage[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH_P; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH_P; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH_P-1];

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - one-pass BRAM address sequencer with aligned MAC result strobe and sum
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int DEPTH   = mac_pkg::DEPTH,
  parameter int ADDR_W  = mac_pkg::ADDR_W,
  parameter int RES_W   = mac_pkg::RES_W,
  parameter int ACC_W   = mac_pkg::ACC_W,
  parameter int RD_LAT  = mac_pkg::RD_LAT,
  parameter int DSP_LAT = mac_pkg::DSP_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [RES_W-1:0]  mac_p,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_idx,
  output logic [ACC_W-1:0]  acc_sum
);

  localparam int                LAT_P   = RD_LAT + DSP_LAT;
  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] len_q;
  logic              len_ok;
  logic              flush;
  tag_t              tag_in;
  tag_t              tag_out;

  assign len_ok = (len != '0) && (len <= DEPTH_L);
  assign flush  = abort && (state != ST_IDLE);

  // The issued address doubles as the element index carried alongside the data
  assign tag_in = '{valid: bram_en, idx: bram_addr};

  mac_tag_pipe #(
    .DEPTH_P (LAT_P)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign res_valid = tag_out.valid;
  assign res_idx   = tag_out.idx;

  // Pass control, issue counter and running sum with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      bram_en   <= 1'b0;
      bram_addr <= '0;
      acc_sum   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (res_valid) acc_sum <= acc_sum + {{(ACC_W-RES_W){1'b0}}, mac_p};

      if (abort && state != ST_IDLE) begin
        state     <= ST_IDLE;
        busy      <= 1'b0;
        bram_en   <= 1'b0;
        bram_addr <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (len_ok) begin
                len_q     <= len;
                acc_sum   <= '0;
                state     <= ST_ISSUE;
                busy      <= 1'b1;
                bram_en   <= 1'b1;
                bram_addr <= '0;
              end else begin
                err <= 1'b1;
              end
            end
          end
          ST_ISSUE: begin
            if (bram_addr == len_q - 1'b1) begin
              state     <= ST_DRAIN;
              bram_en   <= 1'b0;
              bram_addr <= '0;
            end else begin
              bram_addr <= bram_addr + 1'b1;
            end
          end
          ST_DRAIN: begin
            if (res_valid && res_idx == len_q - 1'b1) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - randomized self-checking bench for mac_sequencer
module tb_mac_sequencer;
  import mac_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] len;
  logic              abort;
  logic              busy;
  logic              done;
  logic              err;
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [RES_W-1:0]  mac_p;
  logic              res_valid;
  logic [ADDR_W-1:0] res_idx;
  logic [ACC_W-1:0]  acc_sum;

  int n_vec = 0;
  int n_bad = 0;
  int acc_hold = 0;
  logic [RES_W-1:0] vals [DEPTH];

  mac_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bram_en   (bram_en),
    .bram_addr (bram_addr),
    .mac_p     (mac_p),
    .res_valid (res_valid),
    .res_idx   (res_idx),
    .acc_sum   (acc_sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sum of element values whose result strobe fell in a cycle before c and was not cut off by abort
  function automatic int exp_acc(int n, int c, int abort_cyc);
    int s = 0;
    for (int k = 0; k < n; k++) begin
      int v = 1 + k + LAT;
      if (v < c && (abort_cyc == 0 || v <= abort_cyc)) s += int'(vals[k]);
    end
    return s;
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"}, 32'(busy), 0);
    check({pfx, "_done"}, 32'(done), 0);
    check({pfx, "_err"}, 32'(err), 0);
    check({pfx, "_en"}, 32'(bram_en), 0);
    check({pfx, "_addr"}, 32'(bram_addr), 0);
    check({pfx, "_rv"}, 32'(res_valid), 0);
    check({pfx, "_idx"}, 32'(res_idx), 0);
    check({pfx, "_acc"}, 32'(acc_sum), 0);
  endtask

  // One pass: start accepted at edge 0, every cycle 1..n+LAT+2 compared against timing formulas
  task automatic run_pass(input int n, input int mode, input bit hold,
                          input int mid_start, input int abort_cyc, input int reset_cyc);
    int last = n + LAT + 2;
    for (int k = 0; k < n; k++)
      vals[k] = (mode == 0) ? RES_W'(100 + k) : (mode == 1) ? RES_W'($urandom) : {RES_W{1'b1}};
    start = 1'b1;
    len   = ADDR_W'(n);
    @(posedge clk);
    #1;
    start = hold;
    for (int c = 1; c <= last; c++) begin
      bit aborted = (abort_cyc != 0) && (c > abort_cyc);
      int k       = c - 1 - LAT;
      bit rv      = !aborted && k >= 0 && k < n;
      bit busy_e  = !aborted && c <= n + LAT + 1;
      bit en_e    = !aborted && c <= n;
      bit done_e  = !aborted && c == n + LAT + 1;
      mac_p = rv ? vals[k] : RES_W'($urandom);
      abort = (c == abort_cyc);
      start = hold || (c == mid_start);
      if (c == mid_start) len = ADDR_W'($urandom);
      if (c == reset_cyc) begin
        #2 reset = 1'b1;
        #1 check_all_zero("async_rst");
        @(posedge clk);
        #1;
        reset    = 1'b0;
        abort    = 1'b0;
        start    = 1'b0;
        acc_hold = 0;
        @(negedge clk);
        return;
      end
      @(negedge clk);
      check("busy", 32'(busy), 32'(busy_e));
      check("done", 32'(done), 32'(done_e));
      check("err", 32'(err), 0);
      check("bram_en", 32'(bram_en), 32'(en_e));
      check("bram_addr", 32'(bram_addr), en_e ? c - 1 : 0);
      check("res_valid", 32'(res_valid), 32'(rv));
      if (rv) check("res_idx", 32'(res_idx), k);
      check("acc_sum", 32'(acc_sum), exp_acc(n, c, abort_cyc));
      if (c < last) begin
        @(posedge clk);
        #1;
      end
    end
    abort    = 1'b0;
    acc_hold = exp_acc(n, last, abort_cyc);
  endtask

  task automatic bad_len(input int l);
    start = 1'b1;
    len   = ADDR_W'(l);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("bad_err", 32'(err), 1);
    check("bad_busy", 32'(busy), 0);
    check("bad_en", 32'(bram_en), 0);
    check("bad_acc", 32'(acc_sum), acc_hold);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bad_err_clr", 32'(err), 0);
    check("bad_busy2", 32'(busy), 0);
    check("bad_en2", 32'(bram_en), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    len   = '0;
    mac_p = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    run_pass(10, 0, 1'b0, 0, 0, 0);
    check("sum_basic", 32'(acc_sum), 1045);

    bad_len(0);
    bad_len(11);
    bad_len(15);

    run_pass(1, 2, 1'b0, 0, 0, 0);
    check("sum_single", 32'(acc_sum), 32'h1FFFF);

    run_pass(3, 1, 1'b1, 0, 0, 0);
    run_pass(3, 1, 1'b0, 0, 0, 0);

    run_pass(10, 1, 1'b0, 4, 0, 0);

    run_pass(10, 0, 1'b0, 0, 8, 0);
    check("sum_abort", 32'(acc_sum), 303);

    run_pass(10, 1, 1'b0, 0, 0, 5);
    check_all_zero("post_rst");
    run_pass(10, 1, 1'b0, 0, 0, 0);

    repeat (8) begin
      int n = $urandom_range(1, DEPTH);
      int a = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n + LAT) : 0;
      run_pass(n, 1, 1'b0, 0, a, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
